baud_rate_meter: RTL and testbench

Measures the period of an external square wave (in_sig) in system-clock cycles and reports it as a 25.7 fixed-point half-period value N_meas, the same format the baud rate divider takes as its N input. Writing N_meas into the divider regenerates a clock of the measured frequency. Used for baud auto-detection and for closed-loop checking of divider output on the SPI/GPIO path. Averaging over 2^k periods supplies the fractional bits.

---
 rtl/baud_rate_meter.sv | 161 ++++++++++++++++
 tb/tb_baud_rate_meter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/baud_rate_meter.sv
// baud_rate_meter: measures the period of in_sig in clock cycles, averaged
// over 2^k periods, and reports 64x the mean period (half-period in 25.7).
module baud_rate_meter #(
  parameter int unsigned CNT_W = 25
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        in_sig,
  input  logic        start,
  input  logic [2:0]  log2_periods,
  output logic        busy,
  output logic        valid,
  output logic        overflow,
  output logic [31:0] N_meas
);

  localparam int unsigned RES_W = CNT_W + 6;
  localparam int unsigned PER_W = 7;
  localparam logic [2:0]  K_MAX = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_MEAS
  } state_t;

  logic             s1_q, s2_q, s3_q;
  logic             rise;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PER_W-1:0] per_q, per_d;
  logic [2:0]       k_q, k_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic             overflow_q, overflow_d;
  logic [31:0]      n_meas_q, n_meas_d;

  logic             cnt_max;
  logic [CNT_W-1:0] cnt_inc;
  logic [PER_W-1:0] per_inc;
  logic [PER_W-1:0] per_target;
  logic [RES_W-1:0] avg;

  // Input synchronizer and edge register; runs regardless of enable
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= in_sig;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise = s2_q & ~s3_q;

  // Datapath helpers: counter saturation, period target and scaled result
  always_comb begin
    cnt_max    = (cnt_q == {CNT_W{1'b1}});
    cnt_inc    = cnt_q + CNT_W'(1);
    per_inc    = per_q + PER_W'(1);
    per_target = PER_W'(1) << k_q;
    avg        = RES_W'(cnt_inc) << (K_MAX - k_q);
  end

  // Next-state and output logic; everything holds while enable is low
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    per_d      = per_q;
    k_d        = k_q;
    busy_d     = busy_q;
    valid_d    = valid_q;
    overflow_d = overflow_q;
    n_meas_d   = n_meas_q;
    if (enable) begin
      valid_d = 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            k_d     = (log2_periods > K_MAX) ? K_MAX : log2_periods;
            cnt_d   = '0;
            per_d   = '0;
            busy_d  = 1'b1;
            state_d = ST_ARM;
          end
        end
        ST_ARM: begin
          if (cnt_max) begin
            n_meas_d   = 32'hFFFF_FFFF;
            overflow_d = 1'b1;
            valid_d    = 1'b1;
            busy_d     = 1'b0;
            state_d    = ST_IDLE;
          end else if (rise) begin
            cnt_d   = '0;
            per_d   = '0;
            state_d = ST_MEAS;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        ST_MEAS: begin
          cnt_d = cnt_inc;
          if (cnt_max) begin
            n_meas_d   = 32'hFFFF_FFFF;
            overflow_d = 1'b1;
            valid_d    = 1'b1;
            busy_d     = 1'b0;
            state_d    = ST_IDLE;
          end else if (rise) begin
            per_d = per_inc;
            if (per_inc == per_target) begin
              n_meas_d   = 32'(avg);
              overflow_d = 1'b0;
              valid_d    = 1'b1;
              busy_d     = 1'b0;
              state_d    = ST_IDLE;
            end
          end
        end
        default: begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      per_q      <= '0;
      k_q        <= '0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
      n_meas_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      per_q      <= per_d;
      k_q        <= k_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
      n_meas_q   <= n_meas_d;
    end
  end

  assign busy     = busy_q;
  assign valid    = valid_q;
  assign overflow = overflow_q;
  assign N_meas   = n_meas_q;

endmodule

// File: tb/tb_baud_rate_meter.sv
// Testbench for baud_rate_meter: pattern generator on in_sig plus a
// period-averaging reference model.
module tb_baud_rate_meter;

  localparam int unsigned CNT_W = 8;

  logic        clock;
  logic        reset;
  logic        enable;
  logic        in_sig;
  logic        start;
  logic [2:0]  log2_periods;
  logic        busy;
  logic        valid;
  logic        overflow;
  logic [31:0] N_meas;

  int chk_cnt;
  int pass_cnt;

  // Pattern generator: alternating periods pat_a, pat_b, each high-then-low
  bit          gen_on;
  bit          gen_pause;
  bit          gen_force;
  int unsigned pat_a, pat_b;
  int unsigned g_cnt;
  bit          g_idx;
  bit          g_hi;

  baud_rate_meter #(.CNT_W(CNT_W)) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .in_sig       (in_sig),
    .start        (start),
    .log2_periods (log2_periods),
    .busy         (busy),
    .valid        (valid),
    .overflow     (overflow),
    .N_meas       (N_meas)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int unsigned phase_len(input int unsigned p, input bit hi);
    return hi ? (p - p / 2) : (p / 2);
  endfunction

  always @(posedge clock) begin
    if (!gen_on) begin
      in_sig <= gen_force;
      g_cnt  <= 0;
      g_idx  <= 1'b0;
      g_hi   <= 1'b1;
    end else if (!gen_pause) begin
      in_sig <= g_hi;
      if (g_cnt + 1 >= phase_len(g_idx ? pat_b : pat_a, g_hi)) begin
        g_cnt <= 0;
        if (!g_hi) g_idx <= ~g_idx;
        g_hi <= ~g_hi;
      end else begin
        g_cnt <= g_cnt + 1;
      end
    end
  end

  // Reference: 64 * mean of 2^k consecutive periods of the a,b,a,b... train
  function automatic longint unsigned model_n(input int unsigned a, input int unsigned b,
                                              input int unsigned l2);
    int unsigned k;
    longint unsigned total;
    k = (l2 > 6) ? 6 : l2;
    total = 0;
    for (int i = 0; i < (1 << k); i++) total += (i % 2 == 0) ? a : b;
    return (total * 64) / (longint'(1) << k);
  endfunction

  task automatic gen_set(input int unsigned a, input int unsigned b);
    gen_on = 1'b0;
    pat_a  = a;
    pat_b  = b;
    repeat (4) @(negedge clock);
    gen_on = 1'b1;
  endtask

  task automatic do_start(input logic [2:0] l2);
    @(negedge clock);
    start        = 1'b1;
    log2_periods = l2;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_valid(input int limit, output int n, output bit got);
    got = 1'b0;
    n   = 0;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clock);
      if (valid === 1'b1) begin
        got = 1'b1;
        n   = i;
        return;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b expected 0", busy); else pass_cnt++;
    chk_cnt++; if (valid !== 1'b0) $display("FAIL reset_valid: got %0b expected 0", valid); else pass_cnt++;
    chk_cnt++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %0b expected 0", overflow); else pass_cnt++;
    chk_cnt++; if (N_meas !== 32'd0) $display("FAIL reset_n: got %0h expected 0", N_meas); else pass_cnt++;
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_single_period();
    int n; bit got;
    gen_set(10, 10);
    do_start(3'd0);
    chk_cnt++; if (busy !== 1'b1) $display("FAIL single_busy_rise: got %0b expected 1", busy); else pass_cnt++;
    wait_valid(200, n, got);
    chk_cnt++; if (got !== 1'b1) $display("FAIL single_valid_seen: got %0b expected 1", got); else pass_cnt++;
    chk_cnt++; if (N_meas !== 32'(model_n(10, 10, 0))) $display("FAIL single_n: got %0d expected %0d", N_meas, model_n(10, 10, 0)); else pass_cnt++;
    chk_cnt++; if (overflow !== 1'b0) $display("FAIL single_overflow: got %0b expected 0", overflow); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL single_busy_in_valid: got %0b expected 0", busy); else pass_cnt++;
    @(negedge clock);
    chk_cnt++; if (valid !== 1'b0) $display("FAIL single_valid_pulse: got %0b expected 0", valid); else pass_cnt++;
    chk_cnt++; if (N_meas !== 32'd640) $display("FAIL single_n_hold: got %0d expected 640", N_meas); else pass_cnt++;
  endtask

  task automatic test_averaging();
    int n; bit got;
    gen_set(7, 7);
    do_start(3'd3);
    wait_valid(300, n, got);
    chk_cnt++; if (got !== 1'b1) $display("FAIL avg_valid_seen: got %0b expected 1", got); else pass_cnt++;
    chk_cnt++; if (N_meas !== 32'(model_n(7, 7, 3))) $display("FAIL avg_n: got %0d expected %0d", N_meas, model_n(7, 7, 3)); else pass_cnt++;
  endtask

  task automatic test_fractional(input logic [2:0] l2);
    int n; bit got;
    gen_set(3, 4);
    do_start(l2);
    wait_valid(600, n, got);
    chk_cnt++; if (got !== 1'b1) $display("FAIL frac_valid_seen(l2=%0d): got %0b expected 1", l2, got); else pass_cnt++;
    chk_cnt++; if (N_meas !== 32'(model_n(3, 4, l2))) $display("FAIL frac_n(l2=%0d): got %0d expected %0d", l2, N_meas, model_n(3, 4, l2)); else pass_cnt++;
  endtask

  task automatic test_timeout_arm();
    int n; bit got;
    gen_on = 1'b0; gen_force = 1'b0;
    repeat (4) @(negedge clock);
    do_start(3'd0);
    wait_valid(400, n, got);
    chk_cnt++; if (got !== 1'b1) $display("FAIL to_arm_valid_seen: got %0b expected 1", got); else pass_cnt++;
    chk_cnt++; if (n < 250 || n > 262) $display("FAIL to_arm_latency: got %0d expected about 256", n); else pass_cnt++;
    chk_cnt++; if (overflow !== 1'b1) $display("FAIL to_arm_overflow: got %0b expected 1", overflow); else pass_cnt++;
    chk_cnt++; if (N_meas !== 32'hFFFF_FFFF) $display("FAIL to_arm_n: got %0h expected ffffffff", N_meas); else pass_cnt++;
  endtask

  task automatic test_timeout_meas();
    int n; bit got;
    gen_on = 1'b0; gen_force = 1'b0;
    repeat (4) @(negedge clock);
    do_start(3'd0);
    repeat (20) @(negedge clock);
    gen_set(400, 400);
    wait_valid(400, n, got);
    n = n + 25;
    chk_cnt++; if (got !== 1'b1) $display("FAIL to_meas_valid_seen: got %0b expected 1", got); else pass_cnt++;
    chk_cnt++; if (n < 266 || n > 300) $display("FAIL to_meas_latency: got %0d expected about 284", n); else pass_cnt++;
    chk_cnt++; if (overflow !== 1'b1) $display("FAIL to_meas_overflow: got %0b expected 1", overflow); else pass_cnt++;
    chk_cnt++; if (N_meas !== 32'hFFFF_FFFF) $display("FAIL to_meas_n: got %0h expected ffffffff", N_meas); else pass_cnt++;
  endtask

  task automatic test_start_while_busy();
    int n; bit got;
    gen_set(10, 10);
    do_start(3'd2);
    repeat (14) @(negedge clock);
    do_start(3'd5);
    wait_valid(60, n, got);
    chk_cnt++; if (got !== 1'b1) $display("FAIL busy_start_valid_seen: got %0b expected 1", got); else pass_cnt++;
    chk_cnt++; if (N_meas !== 32'(model_n(10, 10, 2))) $display("FAIL busy_start_n: got %0d expected %0d", N_meas, model_n(10, 10, 2)); else pass_cnt++;
    chk_cnt++; if (overflow !== 1'b0) $display("FAIL busy_start_overflow: got %0b expected 0", overflow); else pass_cnt++;
  endtask

  task automatic test_enable_stall();
    int n; bit got; bit seen;
    gen_set(10, 10);
    do_start(3'd2);
    repeat (15) @(negedge clock);
    for (int i = 0; i < 20 && g_cnt != 4; i++) @(negedge clock);
    enable = 1'b0; gen_pause = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clock);
      if (valid === 1'b1) seen = 1'b1;
    end
    chk_cnt++; if (seen !== 1'b0) $display("FAIL stall_valid_while_disabled: got %0b expected 0", seen); else pass_cnt++;
    enable = 1'b1; gen_pause = 1'b0;
    wait_valid(100, n, got);
    chk_cnt++; if (got !== 1'b1) $display("FAIL stall_valid_seen: got %0b expected 1", got); else pass_cnt++;
    chk_cnt++; if (N_meas !== 32'(model_n(10, 10, 2))) $display("FAIL stall_n: got %0d expected %0d", N_meas, model_n(10, 10, 2)); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int n; bit got;
    gen_set(10, 10);
    do_start(3'd1);
    wait_valid(200, n, got);
    chk_cnt++; if (got !== 1'b1) $display("FAIL b2b_first_valid: got %0b expected 1", got); else pass_cnt++;
    chk_cnt++; if (N_meas !== 32'(model_n(10, 10, 1))) $display("FAIL b2b_first_n: got %0d expected %0d", N_meas, model_n(10, 10, 1)); else pass_cnt++;
    start = 1'b1; log2_periods = 3'd1;
    @(negedge clock);
    start = 1'b0;
    chk_cnt++; if (busy !== 1'b1) $display("FAIL b2b_accepted: got %0b expected 1", busy); else pass_cnt++;
    wait_valid(200, n, got);
    chk_cnt++; if (got !== 1'b1) $display("FAIL b2b_second_valid: got %0b expected 1", got); else pass_cnt++;
    chk_cnt++; if (N_meas !== 32'(model_n(10, 10, 1))) $display("FAIL b2b_second_n: got %0d expected %0d", N_meas, model_n(10, 10, 1)); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    bit seen;
    gen_set(10, 10);
    do_start(3'd3);
    repeat (20) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk_cnt++; if (busy !== 1'b0) $display("FAIL rst_mid_busy: got %0b expected 0", busy); else pass_cnt++;
    chk_cnt++; if (valid !== 1'b0) $display("FAIL rst_mid_valid: got %0b expected 0", valid); else pass_cnt++;
    chk_cnt++; if (overflow !== 1'b0) $display("FAIL rst_mid_overflow: got %0b expected 0", overflow); else pass_cnt++;
    chk_cnt++; if (N_meas !== 32'd0) $display("FAIL rst_mid_n: got %0h expected 0", N_meas); else pass_cnt++;
    reset = 1'b0;
    seen = 1'b0;
    repeat (120) begin
      @(negedge clock);
      if (valid === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    chk_cnt++; if (seen !== 1'b0) $display("FAIL rst_mid_no_activity: got %0b expected 0", seen); else pass_cnt++;
  endtask

  task automatic test_random();
    int n; bit got;
    int unsigned a, b, k, l2;
    longint unsigned exp_n;
    for (int i = 0; i < 8; i++) begin
      a = $urandom_range(2, 12);
      b = (i == 0) ? a : $urandom_range(2, 12);
      k = (i == 0) ? 0 : $urandom_range(1, 6);
      while (k > 1 && ((1 << (k - 1)) * (a + b)) > 230) k--;
      l2 = (k == 6 && $urandom_range(0, 1) == 1) ? 7 : k;
      exp_n = model_n(a, b, l2);
      gen_set(a, b);
      do_start(3'(l2));
      wait_valid(800, n, got);
      chk_cnt++; if (got !== 1'b1) $display("FAIL rand_valid_seen(a=%0d b=%0d l2=%0d): got %0b expected 1", a, b, l2, got); else pass_cnt++;
      chk_cnt++; if (N_meas !== 32'(exp_n)) $display("FAIL rand_n(a=%0d b=%0d l2=%0d): got %0d expected %0d", a, b, l2, N_meas, exp_n); else pass_cnt++;
      chk_cnt++; if (overflow !== 1'b0) $display("FAIL rand_overflow(a=%0d b=%0d l2=%0d): got %0b expected 0", a, b, l2, overflow); else pass_cnt++;
    end
  endtask

  initial begin
    chk_cnt      = 0;
    pass_cnt     = 0;
    reset        = 1'b1;
    enable       = 1'b1;
    start        = 1'b0;
    log2_periods = 3'd0;
    gen_on       = 1'b0;
    gen_pause    = 1'b0;
    gen_force    = 1'b0;
    pat_a        = 10;
    pat_b        = 10;
    test_reset();
    test_single_period();
    test_averaging();
    test_fractional(3'd6);
    test_fractional(3'd7);
    test_timeout_arm();
    test_timeout_meas();
    test_start_while_busy();
    test_enable_stall();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
